lcd_timing_gen: RTL
===================

Name: lcd_timing_gen

Overview:
- Video timing generator downstream of the video PLL; runs on the ~33 MHz video pixel clock (c0 output of the video PLL).
- Produces hsync_n, vsync_n and de for the 800x480 TFT panel, plus the current pixel coordinates.
- Issues a pixel fetch request PREFETCH cycles ahead of display, so the upstream line buffer / framebuffer read has time to return data before de.
- The panel-side clock is the phase-shifted PLL output and is not an input to this block.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 210, horizontal front porch (clocks)
- H_SYNC, 20, hsync pulse width (clocks)
- H_BP, 26, horizontal back porch (clocks); H_TOTAL = 1056
- V_ACTIVE, 480, visible lines per frame
- V_FP, 22, vertical front porch (lines)
- V_SYNC, 10, vsync pulse width (lines)
- V_BP, 13, vertical back porch (lines); V_TOTAL = 525
- PREFETCH, 4, clocks by which req leads de; legal range 1..H_TOTAL-1

Ports:
- clk  in  1  video pixel clock
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable; 0 = freeze all counters and outputs
- hsync_n  out  1  horizontal sync, active low
- vsync_n  out  1  vertical sync, active low
- de  out  1  data enable, high on visible pixels
- x  out  11  column of the pixel currently on de
- y  out  10  row of the pixel currently on de
- frame_start  out  1  one-clock pulse coincident with pixel (0,0)
- line_start  out  1  one-clock pulse coincident with x=0 of every active line
- req  out  1  fetch request for pixel (req_x, req_y)
- req_x  out  11  requested column
- req_y  out  10  requested row

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Counters: two (h,v) pairs, display (dh,dv) and request (rh,rv).
  - h counts 0..H_TOTAL-1, then wraps to 0 and increments v.
  - v counts 0..V_TOTAL-1, then wraps to 0.
  - Counter widths: h 11 bits, v 10 bits.
- Line order: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch. Vertical order uses the same layout.
- Reset values:
  - (dh,dv) = (H_TOTAL-PREFETCH, V_TOTAL-1), i.e. the display runs PREFETCH clocks behind the request counter.
  - (rh,rv) = (0,0).
  - All outputs: hsync_n=1, vsync_n=1, de=0, x=0, y=0, frame_start=0, line_start=0, req=0, req_x=0, req_y=0.
- Each clk edge with en=1 and rst=0:
  - Both counters advance by one.
  - Output registers load the decode of the counter values held before the edge, so outputs lag the counters by exactly 1 clock.
- Display decodes:
  - de = dh<H_ACTIVE && dv<V_ACTIVE
  - hsync_n = !(dh in sync window)
  - vsync_n = !(dv in sync window); vsync transitions align to dh=0.
  - x = dh and y = dv when de=1; otherwise x and y hold their last values.
  - frame_start = (dh==0 && dv==0)
  - line_start = (dh==0 && dv<V_ACTIVE)
- Request decodes:
  - req = rh<H_ACTIVE && rv<V_ACTIVE
  - req_x = rh and req_y = rv when req=1; otherwise they hold.
- Timing invariants:
  - req for pixel P appears exactly PREFETCH clocks before de for P.
  - This holds across line and frame wrap, because both counters wrap independently.
  - After reset, the first req (0,0) appears 1 clock after the first enabled edge. frame_start follows PREFETCH clocks later.
- en=0: counters and all output registers hold their values, including any pulse currently high. Resuming continues seamlessly.
- rst mid-frame: on the next edge, all state returns to reset values regardless of en. rst has priority over en.
- Every request is eventually displayed in order, and no pixel is displayed without a prior request.

Test Plan:
- Reset release, en=1: req=1 with (0,0) on clock 1. frame_start=1, de=1, x=0, y=0 on clock 5. hsync_n and vsync_n stay 1 before that.
- One full line: de high for exactly 800 consecutive clocks. hsync_n low for 20 clocks starting 1010 clocks after line_start. Next line_start comes 1056 clocks after the previous one.
- One full frame: frame_start period = 554400 clocks. vsync_n low for 10 lines, beginning at the dh=0 edge of line 502. 480 line_start pulses per frame.
- Wrap check: at the last pixel (799,479), req for it leads de by 4 clocks. req for (0,0) of the next frame leads frame_start by 4 clocks. Scoreboard the req stream against the de/x/y stream for 2 frames with zero mismatches.
- en toggling: drop en for 37 clocks mid-line (x=400). All outputs frozen for the duration. After resume, x continues at 401 and the line still totals 1056 enabled clocks.
- Reset mid-frame (y=200): the next edge shows reset values on all outputs. Restart reproduces the reset-release sequence exactly.

Source files
------------

// File: rtl/lcd_timing_gen.sv
// Video timing generator for the 800x480 TFT panel: syncs, DE and pixel coordinates,
// plus a fetch-request stream that runs PREFETCH clocks ahead of the display.
module lcd_timing_gen #(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 210,
   parameter int H_SYNC   = 20,
   parameter int H_BP     = 26,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 22,
   parameter int V_SYNC   = 10,
   parameter int V_BP     = 13,
   parameter int PREFETCH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic        hsync_n,
   output logic        vsync_n,
   output logic        de,
   output logic [10:0] x,
   output logic [9:0]  y,
   output logic        frame_start,
   output logic        line_start,
   output logic        req,
   output logic [10:0] req_x,
   output logic [9:0]  req_y
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
   localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] DH_RST = 11'(H_TOTAL - PREFETCH);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [10:0] dh_q, dh_d, rh_q, rh_d;
   logic [9:0]  dv_q, dv_d, rv_q, rv_d;
   logic        hsyncN_q, hsyncN_d, vsyncN_q, vsyncN_d, de_q, de_d;
   logic        frameStart_q, frameStart_d, lineStart_q, lineStart_d, req_q, req_d;
   logic [10:0] x_q, x_d, reqX_q, reqX_d;
   logic [9:0]  y_q, y_d, reqY_q, reqY_d;
   logic        dispActive, reqActive;

   assign dispActive = (dh_q < H_ACT) && (dv_q < V_ACT);
   assign reqActive  = (rh_q < H_ACT) && (rv_q < V_ACT);

   // The display and request counters wrap independently; the display simply
   // starts PREFETCH clocks earlier in the previous frame's last line.
   always_comb begin
      dh_d = dh_q;
      dv_d = dv_q;
      rh_d = rh_q;
      rv_d = rv_q;
      if (en) begin
         if (dh_q == H_LAST) begin
            dh_d = '0;
            dv_d = (dv_q == V_LAST) ? '0 : dv_q + 10'd1;
         end else begin
            dh_d = dh_q + 11'd1;
         end
         if (rh_q == H_LAST) begin
            rh_d = '0;
            rv_d = (rv_q == V_LAST) ? '0 : rv_q + 10'd1;
         end else begin
            rh_d = rh_q + 11'd1;
         end
      end
   end

   always_comb begin
      hsyncN_d     = hsyncN_q;
      vsyncN_d     = vsyncN_q;
      de_d         = de_q;
      frameStart_d = frameStart_q;
      lineStart_d  = lineStart_q;
      req_d        = req_q;
      x_d          = x_q;
      y_d          = y_q;
      reqX_d       = reqX_q;
      reqY_d       = reqY_q;
      if (en) begin
         de_d         = dispActive;
         hsyncN_d     = !((dh_q >= HS_BEG) && (dh_q < HS_END));
         vsyncN_d     = !((dv_q >= VS_BEG) && (dv_q < VS_END));
         frameStart_d = (dh_q == '0) && (dv_q == '0);
         lineStart_d  = (dh_q == '0) && (dv_q < V_ACT);
         req_d        = reqActive;
         if (dispActive) begin
            x_d = dh_q;
            y_d = dv_q;
         end
         if (reqActive) begin
            reqX_d = rh_q;
            reqY_d = rv_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dh_q         <= DH_RST;
         dv_q         <= V_LAST;
         rh_q         <= '0;
         rv_q         <= '0;
         hsyncN_q     <= 1'b1;
         vsyncN_q     <= 1'b1;
         de_q         <= 1'b0;
         frameStart_q <= 1'b0;
         lineStart_q  <= 1'b0;
         req_q        <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         reqX_q       <= '0;
         reqY_q       <= '0;
      end else begin
         dh_q         <= dh_d;
         dv_q         <= dv_d;
         rh_q         <= rh_d;
         rv_q         <= rv_d;
         hsyncN_q     <= hsyncN_d;
         vsyncN_q     <= vsyncN_d;
         de_q         <= de_d;
         frameStart_q <= frameStart_d;
         lineStart_q  <= lineStart_d;
         req_q        <= req_d;
         x_q          <= x_d;
         y_q          <= y_d;
         reqX_q       <= reqX_d;
         reqY_q       <= reqY_d;
      end
   end

   assign hsync_n     = hsyncN_q;
   assign vsync_n     = vsyncN_q;
   assign de          = de_q;
   assign x           = x_q;
   assign y           = y_q;
   assign frame_start = frameStart_q;
   assign line_start  = lineStart_q;
   assign req         = req_q;
   assign req_x       = reqX_q;
   assign req_y       = reqY_q;
endmodule
